// File: rtl/center512_sched.sv
// ============================================================================
// Module      : center512_sched
// Description : Round-robin arbiter that shares one center512 peak/centre
//               engine between NCH capture channels, one frame at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module center512_sched #(
    parameter int NCH       = 4,
    parameter int FRAME_LEN = 512,
    parameter int TIMEOUT   = 1023,
    localparam int CW = $clog2(NCH),
    localparam int NW = $clog2(FRAME_LEN + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   gnt,
    input  logic [NCH*8-1:0] ch_data,
    input  logic [NCH-1:0]   ch_valid,
    output logic [NCH-1:0]   ch_ready,
    output logic [7:0]       eng_data,
    output logic             eng_en,
    input  logic [7:0]       eng_max_data,
    input  logic [8:0]       eng_max_id,
    input  logic [8:0]       eng_cent_id,
    input  logic             eng_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_ch,
    output logic [7:0]       res_max_data,
    output logic [8:0]       res_max_id,
    output logic [8:0]       res_cent_id,
    output logic             res_timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [NW-1:0] c_CNT_LAST = NW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_SEL_LAST = CW'(NCH - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_sel;
    logic [NW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_eng_en;
    logic [7:0]      r_eng_data;
    logic [CW-1:0]   r_res_ch;
    logic [7:0]      r_res_max_data;
    logic [8:0]      r_res_max_id;
    logic [8:0]      r_res_cent_id;
    logic            r_res_timeout;

    logic            w_any;
    logic [CW-1:0]   w_winner;
    logic [NCH-1:0]  w_sel_oh;
    logic [7:0]      w_sel_data;
    logic            w_beat;
    logic            w_tmo_hit;

    // First requester at or after the round-robin pointer; scanning downward
    // lets the smallest offset overwrite the others.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[(int'(r_rr_ptr) + i) % NCH]) begin
                w_any    = 1'b1;
                w_winner = CW'((int'(r_rr_ptr) + i) % NCH);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_sel == CW'(i)) begin
                w_sel_data = ch_data[8*i +: 8];
            end
        end
    end

    assign w_sel_oh  = NCH'(1) << r_sel;
    assign w_tmo_hit = (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        ch_ready    = '0;
        res_valid   = 1'b0;
        w_beat      = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                gnt      = w_sel_oh;
                ch_ready = w_sel_oh;
                w_beat   = ch_valid[r_sel];
                if (w_beat && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                gnt = w_sel_oh;
                if (eng_done || w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                gnt       = w_sel_oh;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr       <= '0;
            r_sel          <= '0;
            r_cnt          <= '0;
            r_tmo          <= '0;
            r_eng_en       <= 1'b0;
            r_eng_data     <= '0;
            r_res_ch       <= '0;
            r_res_max_data <= '0;
            r_res_max_id   <= '0;
            r_res_cent_id  <= '0;
            r_res_timeout  <= 1'b0;
        end else begin
            r_eng_en <= w_beat;
            if (w_beat) begin
                r_eng_data <= w_sel_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel <= w_winner;
                        r_cnt <= '0;
                    end
                end
                S_FEED: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + NW'(1);
                        if (r_cnt == c_CNT_LAST) begin
                            r_tmo <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    // A real answer takes priority over a coincident timeout.
                    if (eng_done) begin
                        r_res_ch       <= r_sel;
                        r_res_max_data <= eng_max_data;
                        r_res_max_id   <= eng_max_id;
                        r_res_cent_id  <= eng_cent_id;
                        r_res_timeout  <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_res_ch       <= r_sel;
                        r_res_max_data <= '0;
                        r_res_max_id   <= '0;
                        r_res_cent_id  <= '0;
                        r_res_timeout  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_rr_ptr <= (r_sel == c_SEL_LAST) ? '0 : r_sel + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_en       = r_eng_en;
    assign eng_data     = r_eng_data;
    assign res_ch       = r_res_ch;
    assign res_max_data = r_res_max_data;
    assign res_max_id   = r_res_max_id;
    assign res_cent_id  = r_res_cent_id;
    assign res_timeout  = r_res_timeout;

endmodule

`default_nettype wire

// File: tb/tb_center512_sched.sv
// ============================================================================
// Module      : tb_center512_sched
// Description : Directed/randomised bench for center512_sched with a
//               behavioural engine model and round-robin reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_center512_sched;

    localparam int NCH = 4;
    localparam int FL  = 512;
    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req       = '0;
    logic [3:0]  gnt;
    logic [31:0] ch_data   = '0;
    logic [3:0]  ch_valid  = '0;
    logic [3:0]  ch_ready;
    logic [7:0]  eng_data;
    logic        eng_en;
    logic [7:0]  eng_max_data = '0;
    logic [8:0]  eng_max_id   = '0;
    logic [8:0]  eng_cent_id  = '0;
    logic        eng_done     = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_ch;
    logic [7:0]  res_max_data;
    logic [8:0]  res_max_id;
    logic [8:0]  res_cent_id;
    logic        res_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    center512_sched #(.NCH(NCH), .FRAME_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .gnt(gnt),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .eng_data(eng_data), .eng_en(eng_en),
        .eng_max_data(eng_max_data), .eng_max_id(eng_max_id),
        .eng_cent_id(eng_cent_id), .eng_done(eng_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_max_data(res_max_data), .res_max_id(res_max_id),
        .res_cent_id(res_cent_id), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine model: logs every eng_en byte and answers 3 cycles after the
    // last byte of a frame; response fields carry junk except on eng_done.
    logic [7:0] eng_log[$];
    int         fcnt = 0;
    int         cd = 0;
    bit         eng_silent = 1'b0;
    logic [7:0] rsp_max  = '0;
    logic [8:0] rsp_id   = '0;
    logic [8:0] rsp_cent = '0;
    int         stray_req = 0;
    int         stray_seen = 0;

    always @(negedge clk) begin
        eng_done     = 1'b0;
        eng_max_data = 8'($urandom);
        eng_max_id   = 9'($urandom);
        eng_cent_id  = 9'($urandom);
        if (!rstn) begin
            fcnt = 0;
            cd   = 0;
        end else begin
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                eng_done   = 1'b1;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done     = 1'b1;
                    eng_max_data = rsp_max;
                    eng_max_id   = rsp_id;
                    eng_cent_id  = rsp_cent;
                end
            end
            if (eng_en) begin
                eng_log.push_back(eng_data);
                fcnt++;
                if (fcnt == FL) begin
                    fcnt = 0;
                    if (!eng_silent) cd = 3;
                end
            end
        end
    end

    logic [7:0] exp_bytes [FL];
    int         rr_ptr_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr_winner(input logic [3:0] r, input int ptr);
        for (int i = 0; i < NCH; i++) begin
            if (r[(ptr + i) % NCH]) return (ptr + i) % NCH;
        end
        return -1;
    endfunction

    // vmode: 0 always valid, 1 valid 1,0,0 repeating, 2 random.
    // dmode: 0 ramp with 0xFF at 300, 1 random bytes.
    task automatic run_frame(input int ch, input int vmode, input int dmode,
                             input int abort_at, output int wcyc);
        int k, cyc, base, gbad, mism;
        logic v;
        wcyc = 0;
        cyc  = 0;
        while (gnt == 4'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant", gnt, 32'(1 << ch));
        chk("busy_feed", busy, 1);
        for (int i = 0; i < FL; i++) begin
            exp_bytes[i] = (dmode == 0) ? ((i == 300) ? 8'hFF : 8'(i)) : 8'($urandom);
        end
        base = eng_log.size();
        k = 0; cyc = 0; gbad = 0;
        while (k < FL && cyc < 4*FL + 100) begin
            if (abort_at >= 0 && k == abort_at) break;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            ch_valid = 4'($urandom);
            ch_data  = $urandom;
            ch_valid[ch] = v;
            ch_data[ch*8 +: 8] = exp_bytes[k];
            #1;
            if (gnt !== 4'(1 << ch)) gbad++;
            if (ch_ready !== 4'(1 << ch)) gbad++;
            if (v) k++;
            @(negedge clk);
            cyc++;
        end
        ch_valid = '0;
        chk("gnt_ready_onehot", gbad, 0);
        if (abort_at >= 0) return;
        chk("beats_accepted", k, FL);
        while (!res_valid && wcyc < TMO + 50) begin
            @(negedge clk);
            wcyc++;
        end
        chk("res_valid_rise", res_valid, 1);
        chk("eng_pulses", eng_log.size() - base, FL);
        mism = 0;
        for (int i = 0; i < FL; i++) begin
            if (base + i >= eng_log.size() || eng_log[base + i] !== exp_bytes[i]) mism++;
        end
        chk("eng_data_order", mism, 0);
        chk("ch_ready_resp", ch_ready, 0);
    endtask

    task automatic check_res(input int ch, input bit to);
        chk("res_ch", res_ch, ch);
        chk("res_max_data", res_max_data, to ? 0 : rsp_max);
        chk("res_max_id", res_max_id, to ? 0 : rsp_id);
        chk("res_cent_id", res_cent_id, to ? 0 : rsp_cent);
        chk("res_timeout", res_timeout, to);
    endtask

    task automatic accept(input int ch);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_fall", res_valid, 0);
        rr_ptr_m = (ch + 1) % NCH;
    endtask

    task automatic new_rsp();
        rsp_max  = 8'($urandom);
        rsp_id   = 9'($urandom);
        rsp_cent = 9'($urandom);
    endtask

    int w, exp_ch, bad;
    logic [31:0] snap_max, snap_id, snap_cent;

    initial begin
        rstn = 1'b0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_ch_ready", ch_ready, 0);
        chk("rst_eng_en", eng_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_fields", {res_ch, res_max_data, res_max_id, res_cent_id, res_timeout}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_no_req", busy, 0);

        // T1: single channel, ramp data with a peak at 300.
        req = 4'b0100;
        rsp_max = 8'hFF; rsp_id = 9'd300; rsp_cent = 9'd300;
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 0, 0, -1, w);
        chk("t1_latency", w, 4);
        check_res(exp_ch, 1'b0);
        req = '0;
        accept(exp_ch);

        // T2: all channels requesting, five frames in round-robin order.
        req = 4'hF;
        for (int f = 0; f < 5; f++) begin
            new_rsp();
            exp_ch = rr_winner(req, rr_ptr_m);
            run_frame(exp_ch, 2, 1, -1, w);
            check_res(exp_ch, 1'b0);
            if (f == 4) req = '0;
            accept(exp_ch);
        end

        // T3: channel 1 with a 1,0,0 valid pattern.
        req = 4'b0010;
        new_rsp();
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 1, 1, -1, w);
        check_res(exp_ch, 1'b0);
        req = '0;
        accept(exp_ch);

        // T4: engine never answers.
        eng_silent = 1'b1;
        req = 4'b1000;
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 0, 1, -1, w);
        chk("t4_timeout_cycles", w, TMO);
        check_res(exp_ch, 1'b1);
        req = '0;
        accept(exp_ch);
        eng_silent = 1'b0;

        // T5: result held off for 20 cycles with others pending.
        req = 4'b0001;
        new_rsp();
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 2, 1, -1, w);
        check_res(exp_ch, 1'b0);
        req = 4'b0110;
        snap_max = 32'(rsp_max); snap_id = 32'(rsp_id); snap_cent = 32'(rsp_cent);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) stray_req++;
            @(negedge clk);
            if (res_valid !== 1'b1 || gnt !== 4'(1 << exp_ch)) bad++;
            if (32'(res_max_data) !== snap_max || 32'(res_max_id) !== snap_id ||
                32'(res_cent_id) !== snap_cent || res_timeout !== 1'b0 ||
                 32'(res_ch) !== 32'(exp_ch)) bad++;
        end
        chk("t5_stall_stable", bad, 0);
        accept(exp_ch);
        new_rsp();
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 0, 1, -1, w);
        check_res(exp_ch, 1'b0);
        req = '0;
        accept(exp_ch);

        // T6: asynchronous reset at beat 200 of channel 0.
        req = 4'b0001;
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 0, 1, 200, w);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_gnt", gnt, 0);
        chk("t6_ch_ready", ch_ready, 0);
        chk("t6_eng_en", eng_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_res_valid", res_valid, 0);
        @(negedge clk);
        @(negedge clk);
        req = 4'b0010;
        rstn = 1'b1;
        rr_ptr_m = 0;
        new_rsp();
        exp_ch = rr_winner(req, rr_ptr_m);
        run_frame(exp_ch, 0, 1, -1, w);
        check_res(exp_ch, 1'b0);
        req = '0;
        accept(exp_ch);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
